// File: rtl/serial_byte_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_byte_capture_if
//  Description : Bundles the serial bit input (data_i/ena_i) and the
//                valid/ready byte output of serial_byte_capture.
//                slave  : the capture block (consumes bits, produces bytes)
//                master : the driving side (bit source + byte consumer)
//  Signals     : data_i    serial bit, meaningful when ena_i=1
//                ena_i     bit-valid strobe
//                m_data_o  head-of-FIFO byte
//                m_valid_o FIFO not empty
//                m_ready_i consumer accepts head byte
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_byte_capture_if;
    logic       data_i;
    logic       ena_i;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;

    modport slave (
        input  data_i,
        input  ena_i,
        input  m_ready_i,
        output m_data_o,
        output m_valid_o
    );

    modport master (
        output data_i,
        output ena_i,
        output m_ready_i,
        input  m_data_o,
        input  m_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/serial_byte_capture.sv
`default_nettype none
// ============================================================================
//  Module      : serial_byte_capture
//  Description : Deserializes an MSB-first bit stream into bytes and buffers
//                them in a first-word-fall-through FIFO with a valid/ready
//                output. Flags stalled partial bytes (idle timeout) and
//                FIFO overflow.
//  Ports       : CLK_I      system clock (rising edge)
//                RST_I      asynchronous active-high reset
//                clr_i      synchronous clear of sticky flags
//                bus        serial input + byte stream (slave modport)
//                level_o    FIFO occupancy 0..DEPTH
//                ovf_o      sticky: completed byte dropped on full FIFO
//                frm_err_o  one-cycle pulse: partial byte discarded
//                drop_cnt_o saturating dropped-byte counter (optional)
//  Options     : define SBC_DROP_CNT_EN to add drop_cnt_o
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_capture #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     clr_i,
    serial_byte_capture_if.slave     bus,
`ifdef SBC_DROP_CNT_EN
    output logic [7:0]               drop_cnt_o,
`endif
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    output logic                     frm_err_o
);

    localparam int c_AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    // Only the 7 oldest bits need storing; the 8th comes straight from data_i.
    logic [6:0]   shreg_q, shreg_d;
    logic         frm_err_q;
    logic         ovf_q, ovf_d;
    logic [c_AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]   mem [DEPTH];

    logic         w_push;
    logic         w_pop;
    logic         w_empty;
    logic         w_full;
    logic         w_accept;
    logic         w_drop;
    logic         w_timeout;
    logic [7:0]   w_byte;

    // ------------------------------------------------------------------
    // Idle timeout (only counts while a partial byte is held)
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam int c_IW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [c_IW-1:0] c_TO_LAST = c_IW'(TIMEOUT_CYC - 1);
            logic [c_IW-1:0] idle_cnt_q, idle_cnt_d;

            // Fires on the idle cycle that brings the count to TIMEOUT_CYC.
            assign w_timeout = (state_q == S_SHIFT) && !bus.ena_i &&
                               (idle_cnt_q == c_TO_LAST);

            always_comb begin
                idle_cnt_d = idle_cnt_q;
                if ((state_q != S_SHIFT) || bus.ena_i || w_timeout)
                    idle_cnt_d = '0;
                else
                    idle_cnt_d = idle_cnt_q + 1'b1;
            end

            always_ff @(posedge CLK_I or posedge RST_I) begin
                if (RST_I) idle_cnt_q <= '0;
                else       idle_cnt_q <= idle_cnt_d;
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Deserializer FSM
    // ------------------------------------------------------------------
    assign w_byte = {shreg_q, bus.data_i};

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        w_push   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ena_i) begin
                    shreg_d  = w_byte[6:0];
                    bitcnt_d = 3'd1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.ena_i) begin
                    shreg_d = w_byte[6:0];
                    if (bitcnt_q == 3'd7) begin
                        w_push   = 1'b1;
                        bitcnt_d = 3'd0;
                        state_d  = S_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else if (w_timeout) begin
                    bitcnt_d = 3'd0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                bitcnt_d = 3'd0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            shreg_q   <= 7'd0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            frm_err_q <= w_timeout;
        end
    end

    // ------------------------------------------------------------------
    // FIFO: extra pointer MSB distinguishes full from empty
    // ------------------------------------------------------------------
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]) &&
                      (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]);
    assign w_pop    = !w_empty && bus.m_ready_i;
    // A pop frees the slot being written, so full+pop still accepts.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_accept) mem[wr_ptr_q[c_AW-1:0]] <= w_byte;
    end

    // Set has priority over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (w_drop)     ovf_d = 1'b1;
        else if (clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

`ifdef SBC_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_i)
            drop_cnt_d = w_drop ? 8'd1 : 8'd0;
        else if (w_drop && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) drop_cnt_q <= 8'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    // Output is forced to zero when empty so stale/unwritten memory never shows.
    assign bus.m_data_o  = w_empty ? 8'h00 : mem[rd_ptr_q[c_AW-1:0]];
    assign bus.m_valid_o = !w_empty;
    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign ovf_o         = ovf_q;
    assign frm_err_o     = frm_err_q;

endmodule
`default_nettype wire
